// File: rtl/afifo_frame_reader.sv
// afifo_frame_reader: parses 2-byte length headers from an async byte FIFO and streams the payload as valid/ready bytes
// Ports:
//   clk, rst_n                 FIFO read clock, async active-low reset
//   fifo_dout, fifo_empty      FIFO read data (one-cycle latency) and empty flag
//   fifo_rd_en                 FIFO read strobe, only raised while not empty
//   m_tdata/m_tvalid/m_tlast   payload byte stream, m_tready from downstream
//   desync                     sticky flag for a zero or oversized length header
//   frame_cnt                  completed-frame counter, wraps at 2^16
module afifo_frame_reader #(
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        desync,
    output logic [15:0] frame_cnt
);
    typedef enum logic [2:0] {HDR_HI, HDR_LO, HDR_CHK, PAYLOAD, DESYNC} state_t;
    state_t      state_q, state_d;
    logic [7:0]  hi_q;
    logic        hi_pend_q, pay_pend_q;
    logic [15:0] rd_left_q, rd_left_d, out_left_q, out_left_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [8:0]  b0_q, b0_d, b1_q, b1_d, in_e;
    logic [15:0] frame_cnt_q, len;
    logic [2:0]  occ;
    logic        bad, pop, push, rd;
    assign len        = {hi_q, fifo_dout};
    assign bad        = (len == 16'd0) || (len > 16'(MAX_LEN));
    assign pop        = (cnt_q != 2'd0) && m_tready;
    assign push       = pay_pend_q;
    // occupancy after this cycle's handshake: lets a read issue in the same cycle a byte leaves
    assign occ        = 3'(cnt_q) + 3'(pay_pend_q) - 3'(pop);
    assign in_e       = {out_left_q == 16'd1, fifo_dout};
    assign fifo_rd_en = rd & rst_n;
    assign m_tvalid   = cnt_q != 2'd0;
    assign m_tdata    = b0_q[7:0];
    assign m_tlast    = b0_q[8];
    assign desync     = (state_q == DESYNC) || (state_q == HDR_CHK && bad);
    assign frame_cnt  = frame_cnt_q;
    always_comb begin
        state_d    = state_q;
        rd         = 1'b0;
        rd_left_d  = rd_left_q;
        out_left_d = push ? out_left_q - 16'd1 : out_left_q;
        case (state_q)
            HDR_HI: begin
                rd      = !fifo_empty;
                state_d = rd ? HDR_LO : HDR_HI;
            end
            HDR_LO: begin
                rd      = !fifo_empty;
                state_d = rd ? HDR_CHK : HDR_LO;
            end
            HDR_CHK: begin
                state_d    = bad ? DESYNC : PAYLOAD;
                rd_left_d  = bad ? rd_left_q : len;
                out_left_d = bad ? out_left_d : len;
            end
            PAYLOAD: begin
                rd        = !fifo_empty && (rd_left_q != 16'd0) && (occ < 3'd2);
                rd_left_d = rd ? rd_left_q - 16'd1 : rd_left_q;
                state_d   = (rd && rd_left_q == 16'd1) ? HDR_HI : PAYLOAD;
            end
            default: ;
        endcase
    end
    // two-entry skid buffer, b0 is always the head
    assign b0_d  = (pop && cnt_q == 2'd2) ? b1_q :
                   (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? in_e : b0_q;
    assign b1_d  = (push && ((pop && cnt_q == 2'd2) || (!pop && cnt_q == 2'd1))) ? in_e : b1_q;
    assign cnt_d = cnt_q + 2'(push) - 2'(pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR_HI;
            hi_q        <= '0;
            hi_pend_q   <= 1'b0;
            pay_pend_q  <= 1'b0;
            rd_left_q   <= '0;
            out_left_q  <= '0;
            cnt_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hi_pend_q   <= fifo_rd_en && state_q == HDR_HI;
            pay_pend_q  <= fifo_rd_en && state_q == PAYLOAD;
            hi_q        <= hi_pend_q ? fifo_dout : hi_q;
            rd_left_q   <= rd_left_d;
            out_left_q  <= out_left_d;
            cnt_q       <= cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            frame_cnt_q <= frame_cnt_q + 16'(pop && b0_q[8]);
        end
    end
endmodule

// File: tb/tb_afifo_frame_reader.sv
// tb_afifo_frame_reader: directed self-checking bench for afifo_frame_reader
module tb_afifo_frame_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, desync;
    logic        m_tready = 1'b1;
    logic [15:0] frame_cnt;
    logic        bp = 1'b0;
    logic [3:0]  pat = 4'b1001;
    logic [7:0]  mem [8192];
    int          wp = 0, rp = 0, under = 0, cyc = 0, t0 = 0, rb = 0, bb = 0;
    int          n_chk = 0, n_err = 0, stab_err = 0, maxdiff = 0, bad = 0;
    int          rd_c[$], bc[$];
    logic [7:0]  bd[$];
    logic        bl[$];
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0]  pd = 8'h00;
    int          sf_rd[5] = '{0, 1, 3, 4, 5};
    logic [7:0]  sf_d[3] = '{8'hA1, 8'hA2, 8'hA3};

    afifo_frame_reader #(.MAX_LEN(1518)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .desync(desync), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: standard-mode one-cycle read latency, flushed while in reset
    always @(posedge clk) begin
        if (!rst_n) rp = wp;
        else if (fifo_rd_en) begin
            if (rp == wp) under++;
            fifo_dout <= mem[rp % 8192];
            rp++;
        end
        #1 fifo_empty = (rp == wp) || !rst_n;
    end

    always @(posedge clk) begin
        #2 m_tready = bp ? pat[cyc % 4] : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) pv = 1'b0;
        else begin
            if (pv && !pr && !(m_tvalid && m_tdata == pd && m_tlast == pl)) stab_err++;
            if (fifo_rd_en) rd_c.push_back(cyc);
            if (m_tvalid && m_tready) begin
                bd.push_back(m_tdata);
                bl.push_back(m_tlast);
                bc.push_back(cyc);
            end
            if (bp && (rd_c.size() - rb - 2) - (bd.size() - bb) > maxdiff)
                maxdiff = (rd_c.size() - rb - 2) - (bd.size() - bb);
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp % 8192] = b;
        wp++;
    endtask

    task automatic mark();
        rb = rd_c.size();
        bb = bd.size();
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (bd.size() - bb < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, bd.size() - bb, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_desync", desync, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        tick(1);

        // single frame
        mark();
        push(8'h00); push(8'h03); push(8'hA1); push(8'hA2); push(8'hA3);
        t0 = cyc + 1;
        tick(12);
        chk("sf_rd_count", rd_c.size() - rb, 5);
        for (int i = 0; i < 5; i++) chk("sf_rd_cycle", rd_c[rb + i] - t0, sf_rd[i]);
        chk("sf_beats", bd.size() - bb, 3);
        for (int i = 0; i < 3; i++) begin
            chk("sf_data", bd[bb + i], sf_d[i]);
            chk("sf_beat_cycle", bc[bb + i] - t0, 5 + i);
            chk("sf_last", bl[bb + i], i == 2);
        end
        chk("sf_frame_cnt", frame_cnt, 1);

        // backpressure
        mark();
        bp = 1'b1;
        push(8'h00); push(8'h10);
        for (int i = 0; i < 16; i++) push(8'(i));
        wait_beats("bp_beats", 16, 200);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (bd[bb + i] != 8'(i) || bl[bb + i] != (i == 15)) bad++;
        chk("bp_data_last", bad, 0);
        chk("bp_stable", stab_err, 0);
        chk("bp_occupancy_over_2", maxdiff > 2, 0);
        bp = 1'b0;
        tick(3);
        chk("bp_frame_cnt", frame_cnt, 2);

        // back-to-back frames
        mark();
        push(8'h00); push(8'h01); push(8'h11);
        push(8'h00); push(8'h02); push(8'h22); push(8'h33);
        wait_beats("b2b_beats", 3, 40);
        chk("b2b_d0", bd[bb], 8'h11);
        chk("b2b_l0", bl[bb], 1);
        chk("b2b_d1", bd[bb + 1], 8'h22);
        chk("b2b_l1", bl[bb + 1], 0);
        chk("b2b_d2", bd[bb + 2], 8'h33);
        chk("b2b_l2", bl[bb + 2], 1);
        tick(3);
        chk("b2b_extra_beats", bd.size() - bb, 3);
        chk("b2b_frame_cnt", frame_cnt, 4);

        // empty gap after two of four payload bytes
        mark();
        push(8'h00); push(8'h04); push(8'hB0); push(8'hB1);
        tick(15);
        chk("gap_beats", bd.size() - bb, 2);
        chk("gap_tvalid", m_tvalid, 0);
        chk("gap_l1", bl[bb + 1], 0);
        push(8'hB2); push(8'hB3);
        wait_beats("gap_resume_beats", 4, 30);
        chk("gap_d2", bd[bb + 2], 8'hB2);
        chk("gap_d3", bd[bb + 3], 8'hB3);
        chk("gap_l2", bl[bb + 2], 0);
        chk("gap_l3", bl[bb + 3], 1);
        tick(2);
        chk("gap_frame_cnt", frame_cnt, 5);

        // largest legal length 1518
        mark();
        push(8'h05); push(8'hEE);
        for (int i = 0; i < 1518; i++) push(8'(i));
        wait_beats("max_beats", 1518, 3000);
        bad = 0;
        for (int i = 0; i < 1518; i++)
            if (bd[bb + i] != 8'(i) || bl[bb + i] != (i == 1517)) bad++;
        chk("max_data_last", bad, 0);
        tick(2);
        chk("max_frame_cnt", frame_cnt, 6);
        chk("max_desync", desync, 0);

        // zero length header
        mark();
        push(8'h00); push(8'h00); push(8'hAA); push(8'hBB);
        t0 = cyc + 1;
        tick(3);
        chk("zero_desync_at_check", desync, 1);
        tick(10);
        chk("zero_rd_count", rd_c.size() - rb, 2);
        chk("zero_beats", bd.size() - bb, 0);
        chk("zero_desync_sticky", desync, 1);

        // oversized header 1519
        do_reset();
        mark();
        push(8'h05); push(8'hEF); push(8'h01); push(8'h02);
        tick(3);
        chk("big_desync_at_check", desync, 1);
        tick(10);
        chk("big_rd_count", rd_c.size() - rb, 2);
        chk("big_beats", bd.size() - bb, 0);
        chk("big_tvalid", m_tvalid, 0);

        // reset mid-frame
        do_reset();
        mark();
        push(8'h00); push(8'h08);
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        wait_beats("mid_pre_beats", 2, 20);
        rst_n = 1'b0;
        #1;
        chk("mid_rd_en", fifo_rd_en, 0);
        chk("mid_tvalid", m_tvalid, 0);
        chk("mid_tdata", m_tdata, 0);
        chk("mid_tlast", m_tlast, 0);
        chk("mid_desync", desync, 0);
        chk("mid_frame_cnt", frame_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        mark();
        push(8'h00); push(8'h01); push(8'h55);
        wait_beats("post_beats", 1, 20);
        tick(4);
        chk("post_beat_count", bd.size() - bb, 1);
        chk("post_data", bd[bb], 8'h55);
        chk("post_last", bl[bb], 1);
        chk("post_frame_cnt", frame_cnt, 1);
        chk("fifo_underflow", under, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/afifo_frame_reader.md
# afifo_frame_reader

Read-side framing stage that sits directly downstream of the 8-bit × 4096 asynchronous byte FIFO, in that FIFO's read clock domain. The FIFO carries Ethernet frames as a 2-byte big-endian length header followed by that many payload bytes. This block parses the header, drains exactly the payload bytes with the FIFO's one-cycle standard-mode read latency hidden, and presents each frame as a valid/ready byte stream with `m_tlast`. Headers that are zero or oversized put the block into a sticky desync state.

## Interface
- `MAX_LEN`, default 1518: largest legal payload length in bytes, range 1..4093.
- `clk` in 1: FIFO read clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_dout` in 8: FIFO read data, valid the cycle after an accepted `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO read strobe.
- `m_tdata` out 8: payload byte.
- `m_tvalid` out 1: `m_tdata` is valid.
- `m_tready` in 1: downstream accepts the byte.
- `m_tlast` out 1: last payload byte of the frame.
- `desync` out 1: sticky; an illegal length header was seen.
- `frame_cnt` out 16: count of completed frames, wraps at 2^16.

## Operation
- Reset values: `fifo_rd_en`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `desync`=0, `frame_cnt`=0. After reset the state is HDR_HI and the output buffer is empty.
- `fifo_rd_en` is only ever asserted when `fifo_empty`=0. Every assertion is therefore an accepted read, and its byte is captured from `fifo_dout` on the following cycle.
- **HDR_HI:** when not empty, assert `fifo_rd_en` for the length high byte, then go to HDR_LO.
- **HDR_LO:** when not empty, assert `fifo_rd_en` for the low byte, then go to HDR_CHK.
- **HDR_CHK** (one cycle): the low byte is captured and `len = {hi, lo}` is formed (16 bits).
  - If `len` = 0 or `len` > `MAX_LEN`: go to DESYNC.
  - Otherwise load `rd_left = len` and `out_left = len`, then go to PAYLOAD.
- **PAYLOAD:** assert `fifo_rd_en` when all of the following hold:
  - not empty;
  - `rd_left` > 0;
  - (bytes held in the output buffer + reads in flight) < 2.
  - Each read decrements `rd_left`. When `rd_left` reaches 0, return to HDR_HI.
- Next-frame header reads may overlap with draining the previous payload from the buffer. Header bytes never enter the output buffer.
- **DESYNC:** `desync`=1 and `fifo_rd_en`=0 permanently. Any payload already buffered from earlier frames still drains normally. Only `rst_n` leaves this state.
- Output buffer: 2-entry skid buffer, each entry holding {data, last}.
  - An entry's `last` is set when `out_left` reaches 1 as the byte is captured; `out_left` decrements on each captured payload byte.
  - `m_tdata`/`m_tlast` are driven from the head entry.
- AXI-style rules:
  - Once `m_tvalid`=1, `m_tdata` and `m_tlast` hold stable until `m_tready`=1.
  - `m_tvalid` is never withdrawn without a handshake.
  - A byte is never duplicated or dropped.
- `frame_cnt` increments on each cycle with `m_tvalid & m_tready & m_tlast`.
- Reset mid-frame: the block returns to reset values immediately. No `m_tlast` is emitted for the aborted frame. The FIFO is reset alongside this block.

## Timing
- Header: with the FIFO non-empty, the `fifo_rd_en` high-byte read is at cycle t, the low-byte read at t+1, length capture/check at t+2, and the first payload `fifo_rd_en` at t+3.
- Payload latency: a `fifo_rd_en` at cycle N produces `m_tvalid` for that byte at N+2 (first byte) when the buffer is empty.
- Throughput: 1 byte/cycle sustained in PAYLOAD with `m_tready`=1 and the FIFO non-empty.
- Per-frame overhead: 3 cycles of header (t..t+2) while the previous frame's tail drains.
- Stalls:
  - `fifo_empty` rising mid-payload stalls reads. `m_tvalid` drops only once the buffer is empty.
  - `m_tready`=0 stops reads within one cycle. The buffer absorbs at most the one in-flight byte.

## Test plan
- **Single frame:** FIFO holds 00 03 A1 A2 A3 (empty falls at cycle 0), `m_tready`=1 → required response:
  - `fifo_rd_en` high at cycles 0–1 and 3–5;
  - beats A1/A2/A3 at cycles 5/6/7;
  - `m_tlast` only with A3;
  - `frame_cnt`=1.
- **Backpressure:** 00 10 followed by 16 bytes 00..0F, `m_tready` toggling 1,0,0,1,… → required response:
  - exactly 00..0F in order, `m_tlast` on 0F;
  - data stable while stalled;
  - never more than 2 bytes buffered or in flight.
- **Back-to-back frames:** 00 01 11 | 00 02 22 33 → required response:
  - beats 11(last), 22, 33(last);
  - `frame_cnt`=2;
  - header bytes never appear on `m_tdata`.
- **Illegal length:**
  - Header 00 00 → `desync`=1 at the check cycle, `fifo_rd_en`=0 thereafter, no `m_tvalid`.
  - Header 05 EF (1519) with `MAX_LEN`=1518 → same response.
  - 05 EE (1518) is accepted and streams 1518 beats.
- **Empty gap:** `fifo_empty`=1 for 10 cycles after 2 of 4 payload bytes → required response:
  - `m_tvalid` drops after the buffered bytes drain;
  - resumes afterwards with the remaining 2 bytes, `m_tlast` on the 4th.
- **Reset mid-frame:** `rst_n` low during byte 3 of 8 → required response:
  - all outputs return to reset values asynchronously;
  - after reset, a fresh frame 00 01 55 yields a single beat 55 with `m_tlast`, and `frame_cnt`=1.
